// File: rtl/rr_arb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_arb_pkg : index types and rotate-search helper shared by the arbiter
// Revision   : 1.0
// ----------------------------------------------------------------------------
package rr_arb_pkg;

  localparam int MAX_N  = 32;
  localparam int MAX_IW = $clog2(MAX_N);

  typedef logic [MAX_IW-1:0] idx_t;

  typedef struct packed {
    logic found;
    idx_t idx;
  } pick_t;

  // Scan n requesters starting one past last_ptr, wrapping by explicit compare
  // so non-power-of-2 counts never produce an out-of-range index.
  function automatic pick_t rr_pick(input logic [MAX_N-1:0] req,
                                    input idx_t             last_ptr,
                                    input int               n);
    pick_t res;
    int    cand;
    res = '0;
    for (int off = 1; off <= MAX_N; off++) begin
      cand = int'(last_ptr) + off;
      if (cand >= n) cand = cand - n;
      if (off <= n && !res.found && req[idx_t'(cand)]) begin
        res.found = 1'b1;
        res.idx   = idx_t'(cand);
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb_delay_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_arb_delay_pipe : async-reset shift register carrying {vld,idx} decisions
// Revision          : 1.0
// ----------------------------------------------------------------------------
module rr_arb_delay_pipe
  import rr_arb_pkg::*;
#(
  parameter int W     = 3,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign q = d;
    end else begin : g_stages
      logic [W-1:0] stage_d [DEPTH];
      logic [W-1:0] stage_q [DEPTH];

      always_comb begin
        stage_d[0] = d;
        for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
          stage_q <= stage_d;
        end
      end

      assign q = stage_q[DEPTH-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/rr_arb_core.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_arb_core : N-way round-robin arbiter with fixed request-to-grant latency
// Revision    : 1.0
// ----------------------------------------------------------------------------
module rr_arb_core
  import rr_arb_pkg::*;
#(
  parameter int N       = 3,
  parameter int REQ2GNT = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 arb_en,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic                 gnt_vld,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int IW = $clog2(N);
  localparam int PW = IW + 1;

  logic [MAX_N-1:0] req_ext;
  pick_t            pick;
  logic             dec_vld;
  logic [IW-1:0]    dec_idx;
  logic [IW-1:0]    last_ptr_d, last_ptr_q;

  logic [PW-1:0]    pipe_out;
  logic             pipe_vld;
  logic [IW-1:0]    pipe_idx;

  logic [N-1:0]     gnt_d, gnt_q;
  logic             gnt_vld_d, gnt_vld_q;
  logic [IW-1:0]    gnt_idx_d, gnt_idx_q;

  // Bubbles carry idx=0 so gnt_idx reads 0 whenever gnt_vld is low.
  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req;
    pick           = rr_pick(req_ext, idx_t'(last_ptr_q), N);
    dec_vld        = arb_en && pick.found;
    dec_idx        = dec_vld ? IW'(pick.idx) : '0;
    last_ptr_d     = dec_vld ? dec_idx : last_ptr_q;
  end

  rr_arb_delay_pipe #(
    .W     (PW),
    .DEPTH (REQ2GNT - 1)
  ) u_pipe (
    .clk   (clk),
    .reset (reset),
    .d     ({dec_vld, dec_idx}),
    .q     (pipe_out)
  );

  always_comb begin
    {pipe_vld, pipe_idx} = pipe_out;
    for (int k = 0; k < N; k++) gnt_d[k] = pipe_vld && (pipe_idx == IW'(k));
    gnt_vld_d = pipe_vld;
    gnt_idx_d = pipe_idx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_ptr_q <= IW'(N - 1);
      gnt_q      <= '0;
      gnt_vld_q  <= 1'b0;
      gnt_idx_q  <= '0;
    end else begin
      last_ptr_q <= last_ptr_d;
      gnt_q      <= gnt_d;
      gnt_vld_q  <= gnt_vld_d;
      gnt_idx_q  <= gnt_idx_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_vld = gnt_vld_q;
  assign gnt_idx = gnt_idx_q;

endmodule
`default_nettype wire
